// File: rtl/seg_display_arbiter_if.sv
// Bundle between the display requesters and seg_display_arbiter.
// The requester side uses the master modport, the arbiter the slave modport.
// Optional: define SEG_ARB_LOCK_EN to add the per-requester lock[3:0] signal.
interface seg_display_arbiter_if;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [31:0]  req_dp;
`ifdef SEG_ARB_LOCK_EN
  logic [3:0]   lock;
`endif
  logic [3:0]   grant;
  logic [1:0]   owner_id;
  logic [31:0]  disp_data;
  logic [7:0]   disp_dp;
  logic         disp_valid;
  logic         switch_pulse;

`ifdef SEG_ARB_LOCK_EN
  modport master (
    output req, req_data, req_dp, lock,
    input  grant, owner_id, disp_data, disp_dp, disp_valid, switch_pulse
  );
  modport slave (
    input  req, req_data, req_dp, lock,
    output grant, owner_id, disp_data, disp_dp, disp_valid, switch_pulse
  );
`else
  modport master (
    output req, req_data, req_dp,
    input  grant, owner_id, disp_data, disp_dp, disp_valid, switch_pulse
  );
  modport slave (
    input  req, req_data, req_dp,
    output grant, owner_id, disp_data, disp_dp, disp_valid, switch_pulse
  );
`endif
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment driver among four
// requesters. An owner keeps the display for at least MIN_HOLD cycles, may be
// preempted after MAX_HOLD cycles when others wait, and a BLANK_CYCLES gap of
// blanked display separates two grants that follow a previous owner.
// Optional: define SEG_ARB_LOCK_EN to let an owner's lock bit suppress the
// MAX_HOLD preemption (release on dropping req is unchanged).
module seg_display_arbiter #(
  parameter int MIN_HOLD     = 50_000_000,
  parameter int MAX_HOLD     = 250_000_000,
  parameter int BLANK_CYCLES = 50_000
) (
  input logic                  clk,
  input logic                  rst,
  seg_display_arbiter_if.slave bus
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, SHARE, BLANK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_id_q, last_id_d;
  logic [1:0]       owner_id_q, owner_id_d;
  logic [3:0]       grant_q, grant_d;
  logic [31:0]      disp_data_q, disp_data_d;
  logic [7:0]       disp_dp_q, disp_dp_d;
  logic             disp_valid_q, disp_valid_d;
  logic             switch_pulse_q, switch_pulse_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BCW-1:0]   blank_cnt_q, blank_cnt_d;

  logic [2:0]       pick;
  logic             pick_vld;
  logic [1:0]       pick_id;
  logic [3:0]       owner_mask;
  logic             owner_req;
  logic             others_req;
  logic             owner_locked;
  logic [31:0]      owner_data;
  logic [7:0]       owner_dp;
  logic             do_grant;
  logic             do_blank;

  // First requester after 'last' in circular order; {found, index}.
  // Scanning from farthest to closest lets the closest hit overwrite the rest.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Hold counter increment that parks at MAX_HOLD-1.
  function automatic logic [HCW-1:0] sat_inc(input logic [HCW-1:0] v);
    return (v == HCW'(MAX_HOLD - 1)) ? v : v + 1'b1;
  endfunction

  // Arbitration inputs, owner lanes and the next-state / output decode.
  always_comb begin
    state_d        = state_q;
    last_id_d      = last_id_q;
    owner_id_d     = owner_id_q;
    grant_d        = grant_q;
    disp_data_d    = disp_data_q;
    disp_dp_d      = disp_dp_q;
    disp_valid_d   = disp_valid_q;
    switch_pulse_d = 1'b0;
    hold_cnt_d     = hold_cnt_q;
    blank_cnt_d    = blank_cnt_q;
    do_grant       = 1'b0;
    do_blank       = 1'b0;

    pick       = rr_pick(bus.req, last_id_q);
    pick_vld   = pick[2];
    pick_id    = pick[1:0];
    owner_mask = 4'b0001 << owner_id_q;
    owner_req  = bus.req[owner_id_q];
    others_req = |(bus.req & ~owner_mask);
    owner_data = bus.req_data[{owner_id_q, 5'b00000} +: 32];
    owner_dp   = bus.req_dp[{owner_id_q, 3'b000} +: 8];
`ifdef SEG_ARB_LOCK_EN
    owner_locked = bus.lock[owner_id_q];
`else
    owner_locked = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_vld) do_grant = 1'b1;
      end
      HOLD: begin
        // Owner cannot release during the minimum hold; data freezes if req drops.
        disp_valid_d = 1'b1;
        if (owner_req) begin
          disp_data_d = owner_data;
          disp_dp_d   = owner_dp;
        end
        hold_cnt_d = sat_inc(hold_cnt_q);
        if (hold_cnt_q == HCW'(MIN_HOLD - 1)) state_d = SHARE;
      end
      SHARE: begin
        if (!owner_req && others_req) begin
          do_blank = 1'b1;
        end else if (!owner_req) begin
          state_d      = IDLE;
          grant_d      = 4'b0000;
          disp_valid_d = 1'b0;
        end else if (others_req && !owner_locked &&
                     hold_cnt_q == HCW'(MAX_HOLD - 1)) begin
          do_blank = 1'b1;
        end else begin
          disp_valid_d = 1'b1;
          disp_data_d  = owner_data;
          disp_dp_d    = owner_dp;
          hold_cnt_d   = sat_inc(hold_cnt_q);
        end
      end
      BLANK: begin
        if (blank_cnt_q == BCW'(BLANK_CYCLES - 1)) begin
          if (pick_vld) do_grant = 1'b1;
          else          state_d  = IDLE;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // New owner: display turns valid one cycle later once its lanes are loaded.
    if (do_grant) begin
      state_d        = HOLD;
      grant_d        = owner_mask_of(pick_id);
      owner_id_d     = pick_id;
      last_id_d      = pick_id;
      switch_pulse_d = 1'b1;
      hold_cnt_d     = '0;
      blank_cnt_d    = '0;
      disp_valid_d   = 1'b0;
    end

    if (do_blank) begin
      state_d      = BLANK;
      grant_d      = 4'b0000;
      disp_valid_d = 1'b0;
      disp_dp_d    = 8'hFF;
      blank_cnt_d  = '0;
    end
  end

  function automatic logic [3:0] owner_mask_of(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  // State, counters and registered outputs; reset aborts any grant at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_id_q      <= 2'd3;
      owner_id_q     <= 2'd0;
      grant_q        <= 4'b0000;
      disp_data_q    <= 32'h0;
      disp_dp_q      <= 8'hFF;
      disp_valid_q   <= 1'b0;
      switch_pulse_q <= 1'b0;
      hold_cnt_q     <= '0;
      blank_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      last_id_q      <= last_id_d;
      owner_id_q     <= owner_id_d;
      grant_q        <= grant_d;
      disp_data_q    <= disp_data_d;
      disp_dp_q      <= disp_dp_d;
      disp_valid_q   <= disp_valid_d;
      switch_pulse_q <= switch_pulse_d;
      hold_cnt_q     <= hold_cnt_d;
      blank_cnt_q    <= blank_cnt_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.owner_id     = owner_id_q;
  assign bus.disp_data    = disp_data_q;
  assign bus.disp_dp      = disp_dp_q;
  assign bus.disp_valid   = disp_valid_q;
  assign bus.switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with MIN_HOLD=4, MAX_HOLD=10,
// BLANK_CYCLES=2. Edge numbering: E0 is the edge that issues a grant.
// The lock scenario is compiled in only when SEG_ARB_LOCK_EN is defined.
module tb_seg_display_arbiter;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(
    .MIN_HOLD    (4),
    .MAX_HOLD    (10),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req = 4'b0000;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 4'b0000;
    tick();
    vec_cnt += 6;
    if (bus.grant !== 4'b0000) begin err_cnt++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
    if (bus.owner_id !== 2'd0) begin err_cnt++; $display("FAIL reset_owner got %0d want 0", bus.owner_id); end
    if (bus.disp_data !== 32'h0) begin err_cnt++; $display("FAIL reset_data got %h want 0", bus.disp_data); end
    if (bus.disp_dp !== 8'hFF) begin err_cnt++; $display("FAIL reset_dp got %h want ff", bus.disp_dp); end
    if (bus.disp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b want 0", bus.disp_valid); end
    if (bus.switch_pulse !== 1'b0) begin err_cnt++; $display("FAIL reset_pulse got %b want 0", bus.switch_pulse); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_first_grant();
    do_reset();
    bus.req_data[31:0] = 32'h1234_5678;
    bus.req_dp[7:0]    = 8'hFE;
    bus.req = 4'b0001;
    tick(); // E0
    vec_cnt += 4;
    if (bus.grant !== 4'b0001) begin err_cnt++; $display("FAIL fg_grant got %b want 0001", bus.grant); end
    if (bus.owner_id !== 2'd0) begin err_cnt++; $display("FAIL fg_owner got %0d want 0", bus.owner_id); end
    if (bus.switch_pulse !== 1'b1) begin err_cnt++; $display("FAIL fg_pulse got %b want 1", bus.switch_pulse); end
    if (bus.disp_valid !== 1'b0) begin err_cnt++; $display("FAIL fg_valid0 got %b want 0", bus.disp_valid); end
    tick(); // E1
    vec_cnt += 5;
    if (bus.grant !== 4'b0001) begin err_cnt++; $display("FAIL fg_grant1 got %b want 0001", bus.grant); end
    if (bus.switch_pulse !== 1'b0) begin err_cnt++; $display("FAIL fg_pulse1 got %b want 0", bus.switch_pulse); end
    if (bus.disp_data !== 32'h1234_5678) begin err_cnt++; $display("FAIL fg_data got %h want 12345678", bus.disp_data); end
    if (bus.disp_dp !== 8'hFE) begin err_cnt++; $display("FAIL fg_dp got %h want fe", bus.disp_dp); end
    if (bus.disp_valid !== 1'b1) begin err_cnt++; $display("FAIL fg_valid got %b want 1", bus.disp_valid); end
    bus.req_data[31:0] = 32'hAABB_CCDD;
    tick(); // E2: lanes tracked every cycle while requesting
    vec_cnt++;
    if (bus.disp_data !== 32'hAABB_CCDD) begin err_cnt++; $display("FAIL fg_track got %h want aabbccdd", bus.disp_data); end
    bus.req = 4'b0000;
  endtask

  task automatic test_min_hold();
    do_reset();
    bus.req_data[31:0] = 32'h0000_1111;
    bus.req_dp[7:0]    = 8'hF0;
    bus.req = 4'b0001;
    tick(); // E0
    tick(); // E1: lanes loaded
    bus.req = 4'b0000;
    bus.req_data[31:0] = 32'hDEAD_BEEF;
    for (int e = 2; e <= 4; e++) begin
      tick();
      vec_cnt += 3;
      if (bus.grant !== 4'b0001) begin err_cnt++; $display("FAIL mh_grant_E%0d got %b want 0001", e, bus.grant); end
      if (bus.disp_data !== 32'h0000_1111) begin err_cnt++; $display("FAIL mh_freeze_E%0d got %h want 00001111", e, bus.disp_data); end
      if (bus.disp_valid !== 1'b1) begin err_cnt++; $display("FAIL mh_valid_E%0d got %b want 1", e, bus.disp_valid); end
    end
    tick(); // E5: SHARE with no requester -> IDLE
    vec_cnt += 3;
    if (bus.grant !== 4'b0000) begin err_cnt++; $display("FAIL mh_release got %b want 0000", bus.grant); end
    if (bus.disp_valid !== 1'b0) begin err_cnt++; $display("FAIL mh_rel_valid got %b want 0", bus.disp_valid); end
    if (bus.owner_id !== 2'd0) begin err_cnt++; $display("FAIL mh_rel_owner got %0d want 0", bus.owner_id); end
  endtask

  task automatic test_preempt();
    do_reset();
    bus.req_data[31:0]  = 32'h1111_1111;
    bus.req_data[95:64] = 32'h2222_2222;
    bus.req_dp[23:16]   = 8'h7F;
    bus.req = 4'b0001;
    tick(); // E0
    tick(); // E1
    tick(); // E2
    bus.req = 4'b0101;
    for (int e = 3; e <= 9; e++) begin
      tick();
      vec_cnt++;
      if (bus.grant !== 4'b0001) begin err_cnt++; $display("FAIL pe_hold_E%0d got %b want 0001", e, bus.grant); end
    end
    for (int e = 10; e <= 11; e++) begin
      tick();
      vec_cnt += 3;
      if (bus.grant !== 4'b0000) begin err_cnt++; $display("FAIL pe_blank_grant_E%0d got %b want 0000", e, bus.grant); end
      if (bus.disp_valid !== 1'b0) begin err_cnt++; $display("FAIL pe_blank_valid_E%0d got %b want 0", e, bus.disp_valid); end
      if (bus.disp_dp !== 8'hFF) begin err_cnt++; $display("FAIL pe_blank_dp_E%0d got %h want ff", e, bus.disp_dp); end
    end
    tick(); // E12
    vec_cnt += 3;
    if (bus.grant !== 4'b0100) begin err_cnt++; $display("FAIL pe_grant got %b want 0100", bus.grant); end
    if (bus.owner_id !== 2'd2) begin err_cnt++; $display("FAIL pe_owner got %0d want 2", bus.owner_id); end
    if (bus.switch_pulse !== 1'b1) begin err_cnt++; $display("FAIL pe_pulse got %b want 1", bus.switch_pulse); end
    tick(); // E13
    vec_cnt += 2;
    if (bus.disp_data !== 32'h2222_2222) begin err_cnt++; $display("FAIL pe_data got %h want 22222222", bus.disp_data); end
    if (bus.disp_dp !== 8'h7F) begin err_cnt++; $display("FAIL pe_dp got %h want 7f", bus.disp_dp); end
    bus.req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [4];
    logic [3:0] prev;
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    do_reset();
    bus.req = 4'b1111;
    tick(); // E0
    vec_cnt++;
    if (bus.grant !== 4'b0001) begin err_cnt++; $display("FAIL rr_first got %b want 0001", bus.grant); end
    prev = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      repeat (9) tick(); // E9
      vec_cnt++;
      if (bus.grant !== prev) begin err_cnt++; $display("FAIL rr_hold%0d got %b want %b", k, bus.grant, prev); end
      tick(); // E10
      vec_cnt += 2;
      if (bus.grant !== 4'b0000) begin err_cnt++; $display("FAIL rr_blank%0d got %b want 0000", k, bus.grant); end
      if (bus.disp_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_bvalid%0d got %b want 0", k, bus.disp_valid); end
      tick(); // E11
      vec_cnt++;
      if (bus.grant !== 4'b0000) begin err_cnt++; $display("FAIL rr_blank2_%0d got %b want 0000", k, bus.grant); end
      tick(); // E12 = next E0
      vec_cnt += 2;
      if (bus.grant !== seq[k]) begin err_cnt++; $display("FAIL rr_grant%0d got %b want %b", k, bus.grant, seq[k]); end
      if (bus.switch_pulse !== 1'b1) begin err_cnt++; $display("FAIL rr_pulse%0d got %b want 1", k, bus.switch_pulse); end
      prev = seq[k];
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req_data[31:0] = 32'h55AA_55AA;
    bus.req = 4'b0001;
    tick(); // E0
    tick(); // E1
    vec_cnt++;
    if (bus.disp_valid !== 1'b1) begin err_cnt++; $display("FAIL ar_pre_valid got %b want 1", bus.disp_valid); end
    #2;
    rst = 1'b0;
    #1;
    vec_cnt += 5;
    if (bus.grant !== 4'b0000) begin err_cnt++; $display("FAIL ar_grant got %b want 0000", bus.grant); end
    if (bus.disp_valid !== 1'b0) begin err_cnt++; $display("FAIL ar_valid got %b want 0", bus.disp_valid); end
    if (bus.disp_data !== 32'h0) begin err_cnt++; $display("FAIL ar_data got %h want 0", bus.disp_data); end
    if (bus.disp_dp !== 8'hFF) begin err_cnt++; $display("FAIL ar_dp got %h want ff", bus.disp_dp); end
    if (bus.owner_id !== 2'd0) begin err_cnt++; $display("FAIL ar_owner got %0d want 0", bus.owner_id); end
    bus.req = 4'b1000;
    #1;
    rst = 1'b1;
    tick();
    vec_cnt += 2;
    if (bus.grant !== 4'b1000) begin err_cnt++; $display("FAIL ar_regrant got %b want 1000", bus.grant); end
    if (bus.owner_id !== 2'd3) begin err_cnt++; $display("FAIL ar_reowner got %0d want 3", bus.owner_id); end
    bus.req = 4'b0000;
  endtask

`ifdef SEG_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.lock = 4'b0001;
    bus.req = 4'b0011;
    tick(); // E0
    repeat (14) tick(); // E14, past the MAX_HOLD point
    vec_cnt++;
    if (bus.grant !== 4'b0001) begin err_cnt++; $display("FAIL lk_hold got %b want 0001", bus.grant); end
    bus.req = 4'b0010;
    tick(); // E15
    vec_cnt++;
    if (bus.grant !== 4'b0000) begin err_cnt++; $display("FAIL lk_blank got %b want 0000", bus.grant); end
    tick(); // E16
    tick(); // E17
    vec_cnt += 2;
    if (bus.grant !== 4'b0010) begin err_cnt++; $display("FAIL lk_grant got %b want 0010", bus.grant); end
    if (bus.owner_id !== 2'd1) begin err_cnt++; $display("FAIL lk_owner got %0d want 1", bus.owner_id); end
    bus.req = 4'b0000;
    bus.lock = 4'b0000;
  endtask
`endif

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b0;
    bus.req = 4'b0000;
    bus.req_data = '0;
    bus.req_dp = '1;
`ifdef SEG_ARB_LOCK_EN
    bus.lock = 4'b0000;
`endif
    test_reset();
    test_first_grant();
    test_min_hold();
    test_preempt();
    test_round_robin();
    test_async_reset();
`ifdef SEG_ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
